// File: rtl/dbi_pkg.sv
// rtl/dbi_pkg.sv - shared constants and helpers for the DBI receive decoder
package dbi_pkg;
    localparam int BW    = 4;
    localparam int LANES = 8;
    localparam int CNT_W = 16;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    // Widened sum so the carry out of a full-width counter is caught before clamping
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, inc};
        if (s > {1'b0, max_val}) return max_val;
        return s[31:0];
    endfunction
endpackage

// File: rtl/dbi_lane_dec.sv
// rtl/dbi_lane_dec.sv - one lane: inversion mux, raw history and transition bound check
module dbi_lane_dec
    import dbi_pkg::*;
#(
    parameter int bw = BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dbi_en,
    input  logic          accept,
    input  logic          flag,
    input  logic [bw-1:0] raw,
    output logic [bw-1:0] data,
    output logic          flag_used,
    output logic          viol
);
    logic [bw-1:0] prev_raw;

    assign flag_used = dbi_en && flag;
    assign data      = flag_used ? ~raw : raw;
    // The bound applies to wire activity, so it is checked on raw bits, not decoded ones
    assign viol      = accept && dbi_en && (popcount(32'(prev_raw ^ raw)) > bw / 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_raw <= '0;
        else if (accept && dbi_en)
            prev_raw <= raw;
    end
endmodule

// File: rtl/dbi_decode.sv
// rtl/dbi_decode.sv - DBI decoder top: lane decoders, 2-entry skid buffer, counters, sticky errors
module dbi_decode
    import dbi_pkg::*;
#(
    parameter int bw    = BW,
    parameter int LANES = dbi_pkg::LANES,
    parameter int CNT_W = dbi_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dbi_en,
    input  logic [LANES*(bw+1)-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*bw-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         inv_cnt,
    output logic [CNT_W-1:0]         word_cnt,
    output logic                     flag_err,
    output logic [LANES-1:0]         bound_err
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [LANES*bw-1:0] dec_data;
    logic [LANES*bw-1:0] main_data, skid_data;
    logic                main_valid, skid_valid;
    logic [LANES-1:0]    flags, flag_used, viol;
    logic [31:0]         inv_inc;
    logic                accept, drain;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign flags[i] = in_data[i*(bw+1)+bw];
        dbi_lane_dec #(.bw(bw)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .dbi_en    (dbi_en),
            .accept    (accept),
            .flag      (flags[i]),
            .raw       (in_data[i*(bw+1) +: bw]),
            .data      (dec_data[i*bw +: bw]),
            .flag_used (flag_used[i]),
            .viol      (viol[i])
        );
    end

    always_comb begin
        inv_inc = '0;
        for (int i = 0; i < LANES; i++) inv_inc = inv_inc + 32'(flag_used[i]);
    end

    // Skid is only ever occupied while in_ready is low, so a drain with skid full never races an accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (drain) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= dec_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_data  <= dec_data;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= dec_data;
                main_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_cnt   <= '0;
            word_cnt  <= '0;
            flag_err  <= 1'b0;
            bound_err <= '0;
        end else if (stats_clr) begin
            inv_cnt   <= '0;
            word_cnt  <= '0;
            flag_err  <= 1'b0;
            bound_err <= '0;
        end else if (accept) begin
            inv_cnt   <= CNT_W'(sat_add(32'(inv_cnt), inv_inc, CNT_MAX));
            word_cnt  <= CNT_W'(sat_add(32'(word_cnt), 32'd1, CNT_MAX));
            flag_err  <= flag_err || (!dbi_en && (|flags));
            bound_err <= bound_err | viol;
        end
    end
endmodule

// File: tb/tb_dbi_decode.sv
// tb/tb_dbi_decode.sv - directed self-checking bench for dbi_decode
module tb_dbi_decode;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dbi_en = 1'b0;
    logic [39:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        stats_clr = 1'b0;
    logic [15:0] inv_cnt, word_cnt;
    logic        flag_err;
    logic [7:0]  bound_err;

    int vecs = 0;
    int errs = 0;

    dbi_decode dut (
        .clk(clk), .reset(reset), .dbi_en(dbi_en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .stats_clr(stats_clr), .inv_cnt(inv_cnt), .word_cnt(word_cnt), .flag_err(flag_err),
        .bound_err(bound_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] put_lane(input logic [39:0] v, input int i,
                                             input logic f, input logic [3:0] d);
        logic [39:0] r;
        r = v;
        r[i*5 +: 4] = d;
        r[i*5 + 4]  = f;
        return r;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stats_clr = 1'b0; dbi_en = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL reset_hs: got %b required 01", {out_valid, in_ready}); end
        vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h required 0", out_data); end
        vecs++; if ({inv_cnt, word_cnt, flag_err, bound_err} !== 41'h0) begin errs++; $display("FAIL reset_stats: got %h/%h/%b/%h required zeros", inv_cnt, word_cnt, flag_err, bound_err); end
    endtask

    task automatic test_single_decode();
        do_reset();
        dbi_en = 1'b1; out_ready = 1'b1;
        in_data = put_lane(40'h0, 0, 1'b1, 4'b0101);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b required 1", out_valid); end
        vecs++; if (out_data !== 32'h0000000A) begin errs++; $display("FAIL single_data: got %h required 0000000a", out_data); end
        vecs++; if (inv_cnt !== 16'd1 || word_cnt !== 16'd1) begin errs++; $display("FAIL single_cnt: got %0d/%0d required 1/1", inv_cnt, word_cnt); end
        step();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int nxt, accs;
        logic wa;
        logic exp_rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        nxt = 1; accs = 0;
        in_data = put_lane(40'h0, 0, 1'b0, 4'd1);
        in_valid = 1'b1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready0: got %b required 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            wa = in_valid && in_ready;
            if (wa) accs++;
            step();
            if (wa) begin nxt++; in_data = put_lane(40'h0, 0, 1'b0, 4'(nxt)); end
            vecs++; if (in_ready !== exp_rdy[c]) begin errs++; $display("FAIL bp_ready c=%0d: got %b required %b", c, in_ready, exp_rdy[c]); end
            vecs++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errs++; $display("FAIL bp_hold c=%0d: got %b/%h required 1/00000001", c, out_valid, out_data); end
        end
        vecs++; if (accs !== 2) begin errs++; $display("FAIL bp_accepts: got %0d required 2", accs); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            wa = in_valid && in_ready;
            vecs++; if (out_valid !== 1'b1 || out_data !== 32'(c + 1)) begin errs++; $display("FAIL bp_order c=%0d: got %b/%h required 1/%h", c, out_valid, out_data, c + 1); end
            step();
            if (wa) begin
                nxt++;
                if (nxt > 6) in_valid = 1'b0;
                else in_data = put_lane(40'h0, 0, 1'b0, 4'(nxt));
            end
        end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty: got %b required 0", out_valid); end
    endtask

    task automatic test_flag_err();
        do_reset();
        dbi_en = 1'b0; out_ready = 1'b1;
        in_data = put_lane(40'h0, 3, 1'b1, 4'b1100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (out_data !== 32'h0000C000) begin errs++; $display("FAIL ferr_data: got %h required 0000c000", out_data); end
        vecs++; if (flag_err !== 1'b1) begin errs++; $display("FAIL ferr_set: got %b required 1", flag_err); end
        vecs++; if (inv_cnt !== 16'd0 || word_cnt !== 16'd1) begin errs++; $display("FAIL ferr_cnt: got %0d/%0d required 0/1", inv_cnt, word_cnt); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        vecs++; if (flag_err !== 1'b0 || word_cnt !== 16'd0) begin errs++; $display("FAIL ferr_clr: got %b/%0d required 0/0", flag_err, word_cnt); end
    endtask

    task automatic test_bound();
        do_reset();
        dbi_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_data = put_lane(put_lane(40'h0, 0, 1'b0, 4'b0111), 1, 1'b0, 4'b0011);
        step();
        vecs++; if (bound_err !== 8'h01) begin errs++; $display("FAIL bound_first: got %h required 01", bound_err); end
        vecs++; if (out_data !== 32'h00000037) begin errs++; $display("FAIL bound_data: got %h required 00000037", out_data); end
        in_data = put_lane(put_lane(40'h0, 0, 1'b0, 4'b0111), 1, 1'b0, 4'b1100);
        step();
        vecs++; if (bound_err !== 8'h03) begin errs++; $display("FAIL bound_lane1: got %h required 03", bound_err); end
        // lane2 jumps to 1111 while disabled: history frozen at 0000, so returning to 0000 is clean
        dbi_en = 1'b0;
        in_data = put_lane(put_lane(put_lane(40'h0, 0, 1'b0, 4'b0111), 1, 1'b0, 4'b1100), 2, 1'b0, 4'b1111);
        step();
        dbi_en = 1'b1;
        in_data = put_lane(put_lane(40'h0, 0, 1'b0, 4'b0111), 1, 1'b0, 4'b1100);
        step();
        in_valid = 1'b0;
        vecs++; if (bound_err !== 8'h03) begin errs++; $display("FAIL bound_frozen: got %h required 03", bound_err); end
    endtask

    task automatic test_saturation();
        logic [39:0] all8, six;
        do_reset();
        all8 = '0; six = '0;
        for (int i = 0; i < 8; i++) all8 = put_lane(all8, i, 1'b1, 4'b0000);
        for (int i = 0; i < 6; i++) six = put_lane(six, i, 1'b1, 4'b0000);
        dbi_en = 1'b1; out_ready = 1'b1;
        in_data = all8; in_valid = 1'b1;
        repeat (8191) step();
        in_data = six;
        step();
        in_valid = 1'b0;
        vecs++; if (inv_cnt !== 16'd65534 || word_cnt !== 16'd8192) begin errs++; $display("FAIL sat_preset: got %0d/%0d required 65534/8192", inv_cnt, word_cnt); end
        in_data = all8; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vecs++; if (inv_cnt !== 16'd65535) begin errs++; $display("FAIL sat_clamp: got %0d required 65535", inv_cnt); end
        in_valid = 1'b1;
        step();
        vecs++; if (inv_cnt !== 16'd65535 || word_cnt !== 16'd8194) begin errs++; $display("FAIL sat_hold: got %0d/%0d required 65535/8194", inv_cnt, word_cnt); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0; in_valid = 1'b0;
        vecs++; if (inv_cnt !== 16'd0 || word_cnt !== 16'd0) begin errs++; $display("FAIL sat_clr: got %0d/%0d required 0/0", inv_cnt, word_cnt); end
    endtask

    task automatic test_reset_loopback();
        logic [3:0]  tx_prev [8];
        logic [3:0]  d;
        logic [31:0] src;
        do_reset();
        dbi_en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        in_data = put_lane(40'h0, 0, 1'b0, 4'b0001);
        step();
        in_data = put_lane(40'h0, 0, 1'b0, 4'b0010);
        step();
        in_valid = 1'b0;
        vecs++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errs++; $display("FAIL full_state: got %b/%b required 0/1", in_ready, out_valid); end
        #2 reset = 1'b1;
        #1;
        vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin errs++; $display("FAIL async_reset: got %b/%b/%h required 0/1/0", out_valid, in_ready, out_data); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tx_prev[i] = 4'h0;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            src = '0;
            for (int i = 0; i < 8; i++) begin
                d = 4'($urandom_range(0, 15));
                src[i*4 +: 4] = d;
                if ($countones(tx_prev[i] ^ d) > 2) begin
                    in_data = put_lane(in_data, i, 1'b1, ~d);
                    tx_prev[i] = ~d;
                end else begin
                    in_data = put_lane(in_data, i, 1'b0, d);
                    tx_prev[i] = d;
                end
            end
            step();
            vecs++; if (out_valid !== 1'b1 || out_data !== src) begin errs++; $display("FAIL loop k=%0d: got %b/%h required 1/%h", k, out_valid, out_data, src); end
        end
        in_valid = 1'b0;
        vecs++; if (bound_err !== 8'h00) begin errs++; $display("FAIL loop_bound: got %h required 00", bound_err); end
    endtask

    initial begin
        test_reset();
        test_single_decode();
        test_backpressure();
        test_flag_err();
        test_bound();
        test_saturation();
        test_reset_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
